// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor for one restoring-division step.
module div_trial_sub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           nonneg
);

    // The partial remainder stays below the divisor, so a < 2*b and the
    // difference always fits a WIDTH+1-bit two's complement value.
    assign diff   = a - b;
    assign nonneg = ~diff[WIDTH];

endmodule

// File: rtl/seq_divider8.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Optional SIGNED_DIV_EN: two's complement operands with a sign-fix state.
module seq_divider8
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;
`ifdef SIGNED_DIV_EN
    localparam logic [1:0] S_FIX  = FIX;
`endif
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [WIDTH-1:0] dvd, dvs, rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   shifted, diff;
    logic             nonneg;
    logic [WIDTH-1:0] q_nxt, r_nxt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             diff_msb_unused;

`ifdef SIGNED_DIV_EN
    logic neg_q, neg_r;
    assign a_mag = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    assign b_mag = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    assign shifted = {rem, dvd[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .a      (shifted),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .nonneg (nonneg)
    );

    assign diff_msb_unused = diff[WIDTH];
    assign q_nxt = {dvd[WIDTH-2:0], nonneg};
    assign r_nxt = nonneg ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

`ifdef SIGNED_DIV_EN
    assign busy = (state == S_RUN) || (state == S_FIX);
`else
    assign busy = (state == S_RUN);
`endif
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= S_RUN;
                            dvd         <= a_mag;
                            dvs         <= b_mag;
                            rem         <= '0;
                            cnt         <= CW'(WIDTH - 1);
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
                            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            neg_r       <= dividend[WIDTH-1];
`endif
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    dvd <= q_nxt;
                    rem <= r_nxt;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
`ifdef SIGNED_DIV_EN
                        state     <= S_FIX;
`else
                        state     <= S_DONE;
                        quotient  <= q_nxt;
                        remainder <= r_nxt;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                // Magnitudes are divided; signs are reapplied here so the
                // quotient truncates toward zero and the remainder follows the dividend.
                S_FIX: begin
                    state     <= S_DONE;
                    quotient  <= neg_q ? (~dvd + ONE) : dvd;
                    remainder <= neg_r ? (~rem + ONE) : rem;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8 with an arithmetic reference model and per-cycle compare.
module tb_seq_divider8;

    localparam int W = 8;
`ifdef SIGNED_DIV_EN
    localparam int RUNLEN = W + 1;
    localparam logic [W-1:0] Q200 = 8'hF8;
    localparam logic [W-1:0] R200 = 8'h00;
`else
    localparam int RUNLEN = W;
    localparam logic [W-1:0] Q200 = 8'd28;
    localparam logic [W-1:0] R200 = 8'd4;
`endif
    localparam int LAT = RUNLEN + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_chk  = 0;
    int n_pass = 0;

    seq_divider8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
`ifdef SIGNED_DIV_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        q  = W'(sa / sb);
        r  = W'(sa % sb);
`else
        q = a / b;
        r = a % b;
`endif
    endfunction

    // Reference model: tracks only "how many cycles remain" and the arithmetic result.
    logic         m_busy, m_done, m_z;
    logic [W-1:0] m_q, m_r, p_q, p_r;
    int           m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_z = 1'b0;
            m_q = '0; m_r = '0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_q = p_q; m_r = p_r;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    m_done = 1'b1; m_q = '1; m_r = dividend; m_z = 1'b1;
                end else begin
                    m_busy = 1'b1; m_cnt = RUNLEN;
                    m_q = '0; m_r = '0; m_z = 1'b0;
                    calc(dividend, divisor, p_q, p_r);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("quotient", quotient, m_q);
        chk("remainder", remainder, m_r);
        chk("div_by_zero", div_by_zero, m_z);
    end

    // Called just after a falling edge; drives at once so the next rising edge samples start.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                          input int lat, input bit glitch, input string nm);
        int n;
        bit got;
        start = 1'b1; dividend = a; divisor = b;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = done;
            if (n == 1) start = 1'b0;
            if (n == 2) begin dividend = ~a; divisor = b + 8'd1; end
            if (glitch && n == 3) begin start = 1'b1; dividend = 8'd9; divisor = 8'd3; end
            if (glitch && n == 4) start = 1'b0;
        end
        start = 1'b0;
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_div(8'd200, 8'd7, Q200, R200, 1'b0, LAT, 1'b0, "d200_7");
        @(negedge clk);
        do_div(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1, 1'b0, "d5_0");
        @(negedge clk);
        do_div(8'd7, 8'd9, 8'd0, 8'd7, 1'b0, LAT, 1'b0, "d7_9");
        do_div(8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, LAT, 1'b0, "b2b_255_1");
        @(negedge clk);
        do_div(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, LAT, 1'b1, "d100_3_glitch");
        @(negedge clk);

        // Abort mid-run: outputs clear asynchronously and no done follows.
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        do_div(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, LAT, 1'b0, "d50_5");
        @(negedge clk);
        do_div(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT, 1'b0, "d255_255");
        @(negedge clk);
        do_div(8'd0, 8'd5, 8'd0, 8'd0, 1'b0, LAT, 1'b0, "d0_5");
`ifdef SIGNED_DIV_EN
        @(negedge clk);
        do_div(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, LAT, 1'b0, "s_m100_7");
        @(negedge clk);
        do_div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, 1'b0, "s_min_m1");
        @(negedge clk);
        do_div(8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, LAT, 1'b0, "s_100_m7");
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
